// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
//
// Shared definitions for the reg_file_mem register-file memory:
//   - DEF_WIDTH / DEF_DEPTH : default word width and word count
//   - state_t               : clear sequencer states (IDLE, CLEAR)
//   - clog2_min1()          : address width helper, never returns less than 1
//
// No ports (package).
// ---------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Clear sequencer state. IDLE accepts accesses, CLEAR walks the array
  // writing zeros and blocks all accesses.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // $clog2(2) is 1, but $clog2(1) is 0; clamp so an address bus always
  // has at least one bit and never collapses to a zero-width vector.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_file_mem_if.sv
// ---------------------------------------------------------------------------
// reg_file_mem_if
//
// Access bus of the reg_file_mem register file.
//
// Parameters:
//   WIDTH : data bits per word
//   DEPTH : number of words (address width derived from it)
//
// Signals:
//   en        master->slave  chip enable; no access while 0
//   wr_bar    master->slave  active-low write strobe
//   rd_bar    master->slave  active-low read strobe
//   addr      master->slave  word address for read and write
//   din       master->slave  write data
//   clr_req   master->slave  one-cycle request to zero every word
//   dout      slave->master  registered read data
//   rd_valid  slave->master  one-cycle pulse, dout carries new read data
//   busy      slave->master  clear sequence in progress
//   dbg_state slave->master  current clear sequencer state (observation)
//
// Transfer semantics: a request is taken when en=1, busy=0 and clr_req=0
// at a rising edge; there is no back-pressure, so a master that samples
// busy=0 knows its strobes are consumed in that cycle. A read taken at edge
// N answers with rd_valid=1 and its data on dout between edges N and N+1;
// rd_valid is a pure pulse and never waits for the master.
//
// Modports:
//   master : the block issuing accesses
//   slave  : the register file itself
// ---------------------------------------------------------------------------
interface reg_file_mem_if
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int AW = clog2_min1(DEPTH);

  logic             en;
  logic             wr_bar;
  logic             rd_bar;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] din;
  logic             clr_req;
  logic [WIDTH-1:0] dout;
  logic             rd_valid;
  logic             busy;
  state_t           dbg_state;

  modport master (
    output en,
    output wr_bar,
    output rd_bar,
    output addr,
    output din,
    output clr_req,
    input  dout,
    input  rd_valid,
    input  busy,
    input  dbg_state
  );

  modport slave (
    input  en,
    input  wr_bar,
    input  rd_bar,
    input  addr,
    input  din,
    input  clr_req,
    output dout,
    output rd_valid,
    output busy,
    output dbg_state
  );

endinterface

// File: rtl/reg_word.sv
// ---------------------------------------------------------------------------
// reg_word
//
// One WIDTH-bit row of the register file. Synchronous write, synchronous
// clear, deliberately no reset: array contents survive a reset and are only
// defined once written or cleared.
//
// Ports:
//   clk : rising-edge clock
//   we  : write enable, q <= d at the edge
//   d   : write data
//   clr : synchronous clear, q <= 0 at the edge (wins over we)
//   q   : stored word
// ---------------------------------------------------------------------------
module reg_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_mem.sv
// ---------------------------------------------------------------------------
// reg_file_mem
//
// DEPTH x WIDTH register-file memory with active-low strobes, chip enable,
// registered read with a one-cycle valid pulse, write-first forwarding when
// a read and a write hit the same address in one cycle, and a hardware
// bulk-clear sequencer that zeroes every word, one per cycle, while busy=1.
//
// Parameters:
//   WIDTH : data bits per word (>= 1)
//   DEPTH : number of words (>= 2, any value, not only powers of 2)
//   Address width is derived internally as clog2_min1(DEPTH).
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (output stage and sequencer only;
//           the storage array keeps its contents)
//   bus   : reg_file_mem_if.slave access bus (en, wr_bar, rd_bar, addr,
//           din, clr_req in; dout, rd_valid, busy, dbg_state out)
//
// Configuration macro:
//   REG_FILE_TRISTATE_OUT_EN : when defined, dout is driven only while
//   rd_valid=1 and floats ('z) otherwise, so several instances can share
//   one read bus. When undefined, dout always holds the last read value.
// ---------------------------------------------------------------------------
module reg_file_mem
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_file_mem_if.slave  bus
);

  localparam int AW = clog2_min1(DEPTH);

  // DEPTH expressed one bit wider than the address so the range check is
  // exact even when DEPTH is a power of two.
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  // ------------------------------------------------------------------------
  // Declarations
  // ------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic [AW-1:0]    cnt_q;
  logic [AW-1:0]    cnt_d;

  logic             acc_ok;
  logic             in_range;
  logic             wr_go;
  logic             rd_go;

  logic [WIDTH-1:0] row_q [DEPTH];
  logic [DEPTH-1:0] row_we;
  logic [DEPTH-1:0] row_clr;

  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd_next;

  logic [WIDTH-1:0] dout_q;
  logic             rd_valid_q;

  // ------------------------------------------------------------------------
  // Access qualification
  // ------------------------------------------------------------------------
  // A clear request in IDLE takes the cycle; any access alongside it is
  // dropped. In CLEAR every strobe is ignored.
  assign acc_ok   = bus.en & (state_q == IDLE) & ~bus.clr_req;
  assign in_range = ({1'b0, bus.addr} < DEPTH_W);

  // Array writes are gated with rst_n so that a reset edge never modifies
  // storage: an aborted clear leaves unreached words untouched.
  assign wr_go = rst_n & acc_ok & ~bus.wr_bar & in_range;
  assign rd_go = acc_ok & ~bus.rd_bar;

  // ------------------------------------------------------------------------
  // Clear sequencer: state register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ------------------------------------------------------------------------
  // Clear sequencer: next state
  // ------------------------------------------------------------------------
  // clr_req at edge N enters CLEAR; edges N+1..N+DEPTH clear words
  // 0..DEPTH-1, and the edge that clears the last word returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Storage rows
  // ------------------------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    assign row_we[i]  = wr_go & (bus.addr == AW'(i));
    assign row_clr[i] = rst_n & (state_q == CLEAR) & (cnt_q == AW'(i));

    reg_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk (clk),
      .we  (row_we[i]),
      .d   (bus.din),
      .clr (row_clr[i]),
      .q   (row_q[i])
    );
  end

  // ------------------------------------------------------------------------
  // Read path
  // ------------------------------------------------------------------------
  // Decoding against every row index leaves rd_word at 0 for addresses at
  // or beyond DEPTH, which is exactly the out-of-range read result.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.addr == AW'(i)) begin
        rd_word = row_q[i];
      end
    end
  end

  // Write-first: a same-cycle write to the read address returns the new
  // data. wr_go already excludes out-of-range writes, so a dropped write
  // is never forwarded.
  assign rd_next = wr_go ? bus.din : rd_word;

  // ------------------------------------------------------------------------
  // Registered output stage
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_go;
      if (rd_go) begin
        dout_q <= rd_next;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
`ifdef REG_FILE_TRISTATE_OUT_EN
  assign bus.dout = rd_valid_q ? dout_q : {WIDTH{1'bz}};
`else
  assign bus.dout = dout_q;
`endif

  assign bus.rd_valid  = rd_valid_q;
  assign bus.busy      = (state_q == CLEAR);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_reg_file_mem.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mem
//
// Self-checking bench for reg_file_mem. A DEPTH=16 instance is driven
// through one task that also advances a behavioural model (word array with
// known flags, a busy countdown and a clear pointer); a DEPTH=10 instance
// covers out-of-range addresses. Honours REG_FILE_TRISTATE_OUT_EN.
// ---------------------------------------------------------------------------
module tb_reg_file_mem;
  import reg_file_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_mem_if #(.WIDTH(W), .DEPTH(DEPTH)) m_if ();
  reg_file_mem_if #(.WIDTH(W), .DEPTH(10))    s_if ();

  reg_file_mem #(.WIDTH(W), .DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if)
  );

  reg_file_mem #(.WIDTH(W), .DEPTH(10)) u_d10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] ref_mem   [DEPTH];
  bit           ref_known [DEPTH];
  int           busy_left = 0;
  int           clr_ptr   = 0;
  logic [W-1:0] exp_q[$];
  bit           known_q[$];
  logic [W-1:0] hold_val  = '0;
  bit           hold_known = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the DEPTH=16 instance, advance the model across the
  // edge, then compare rd_valid, busy and dout.
  task automatic cycle(input logic rn, input logic e, input logic wb, input logic rb,
                       input logic [3:0] a, input logic [W-1:0] d, input logic cr);
    bit rd;
    bit wr;
    rd = 1'b0;
    wr = 1'b0;
    rst_n        = rn;
    m_if.en      = e;
    m_if.wr_bar  = wb;
    m_if.rd_bar  = rb;
    m_if.addr    = a;
    m_if.din     = d;
    m_if.clr_req = cr;

    if (!rn) begin
      busy_left = 0;
      exp_q.delete();
      known_q.delete();
      hold_val   = '0;
      hold_known = 1'b1;
    end else if (busy_left > 0) begin
      if (clr_ptr < DEPTH) begin
        ref_mem[clr_ptr]   = '0;
        ref_known[clr_ptr] = 1'b1;
      end
      clr_ptr++;
      busy_left--;
    end else if (cr) begin
      busy_left = DEPTH;
      clr_ptr   = 0;
    end else begin
      rd = e && !rb;
      wr = e && !wb;
      if (rd) begin
        exp_q.push_back(wr ? d : ref_mem[a]);
        known_q.push_back(wr || ref_known[a]);
      end
      if (wr) begin
        ref_mem[a]   = d;
        ref_known[a] = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    check("rd_valid", m_if.rd_valid, rd);
    check("busy", m_if.busy, busy_left > 0);
    if (rd) begin
      hold_val   = exp_q.pop_front();
      hold_known = known_q.pop_front();
      if (hold_known) check("dout_read", m_if.dout, hold_val);
    end else begin
`ifdef REG_FILE_TRISTATE_OUT_EN
      check("dout_z", m_if.dout, {W{1'bz}});
`else
      if (hold_known) check("dout_hold", m_if.dout, hold_val);
`endif
    end
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 1'b0);
  endtask

  task automatic d10_drive(input logic e, input logic wb, input logic rb,
                           input logic [3:0] a, input logic [W-1:0] d);
    s_if.en      = e;
    s_if.wr_bar  = wb;
    s_if.rd_bar  = rb;
    s_if.addr    = a;
    s_if.din     = d;
    s_if.clr_req = 1'b0;
    idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]   = '0;
      ref_known[i] = 1'b0;
    end
    s_if.en = 1'b0; s_if.wr_bar = 1'b1; s_if.rd_bar = 1'b1;
    s_if.addr = '0; s_if.din = '0; s_if.clr_req = 1'b0;

    // Reset, with a read strobe held to show it is ignored.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 8'h00, 1'b0);
    check("reset_state", m_if.dbg_state, IDLE);
`ifdef REG_FILE_TRISTATE_OUT_EN
    check("reset_dout", m_if.dout, {W{1'bz}});
`else
    check("reset_dout", m_if.dout, 8'h00);
`endif

    // Write then read addr 3.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 8'hA5, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    check("rd_a5", m_if.dout, 8'hA5);
    idle();

    // Same-cycle write and read at addr 7: write-first.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 8'h3C, 1'b0);
    check("fwd_3c", m_if.dout, 8'h3C);

    // Fill, then clear; the access beside clr_req is dropped.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'(i), 8'(i) ^ 8'h55, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'hFF, 1'b1);
    check("clr_state", m_if.dbg_state, CLEAR);
    busy_cnt = 0;
    while (m_if.busy === 1'b1 && busy_cnt < 40) begin
      busy_cnt++;
      cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    check("busy_cycles", busy_cnt, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'(i), 8'h00, 1'b0);
      check("clr_word", m_if.dout, 8'h00);
    end

    // Chip enable low: no write, no read.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 8'hFF, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
    check("en_low_word2", m_if.dout, 8'h00);

    // Randomized traffic with occasional clears.
    for (int k = 0; k < 300; k++) begin
      cycle(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 39) == 0));
    end
    while (m_if.busy === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      idle();
    end

    // DEPTH=10 instance: out-of-range writes dropped, reads return 0.
    d10_drive(1'b1, 1'b0, 1'b1, 4'd4, 8'h11);
    d10_drive(1'b1, 1'b0, 1'b1, 4'd9, 8'h99);
    d10_drive(1'b1, 1'b0, 1'b1, 4'd12, 8'h77);
    check("d10_wr_novalid", s_if.rd_valid, 1'b0);
    d10_drive(1'b1, 1'b1, 1'b0, 4'd12, 8'h00);
    check("d10_oor_valid", s_if.rd_valid, 1'b1);
    check("d10_oor_dout", s_if.dout, 8'h00);
    d10_drive(1'b1, 1'b0, 1'b0, 4'd12, 8'h77);
    check("d10_oor_nofwd", s_if.dout, 8'h00);
    d10_drive(1'b1, 1'b1, 1'b0, 4'd4, 8'h00);
    check("d10_word4", s_if.dout, 8'h11);
    d10_drive(1'b1, 1'b1, 1'b0, 4'd9, 8'h00);
    check("d10_word9", s_if.dout, 8'h99);
    d10_drive(1'b0, 1'b1, 1'b0, 4'd9, 8'h00);
    check("d10_en_low", s_if.rd_valid, 1'b0);

    // Reset in the middle of a clear.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'(i), 8'(i) ^ 8'hA0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) idle();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 1'b0);
    check("abort_busy", m_if.busy, 1'b0);
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'(i), 8'h00, 1'b0);
      check("abort_word", m_if.dout, (i < 5) ? 8'h00 : (8'(i) ^ 8'hA0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_mem.md
Name: reg_file_mem

Overview:
- Parametrised successor to the single-bit storage cell: a DEPTH x WIDTH register-file memory built from word-wide rows.
- Keeps the active-low read/write strobes and chip enable.
- Adds a registered read with a valid pulse, same-address write-first forwarding, and a hardware bulk-clear sequencer with a busy flag.
- Used as the small local storage array in datapath and scratchpad blocks.

Parameters:
- WIDTH, 8, data bits per word (>=1)
- DEPTH, 16, number of words (>=2; need not be a power of 2)
- AW, $clog2(DEPTH), address width (derived; do not override)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  chip enable; no access occurs when 0
- wr_bar  in  1  active-low write strobe
- rd_bar  in  1  active-low read strobe
- addr  in  AW  word address for read and write
- din  in  WIDTH  write data
- clr_req  in  1  one-cycle request to zero all words
- dout  out  WIDTH  read data, registered
- rd_valid  out  1  one-cycle pulse when dout carries new read data
- busy  out  1  high while the clear sequence runs

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low, sampled on the rising edge of clk.
- While rst_n=0 at an edge:
  - dout=0, rd_valid=0, busy=0, state=IDLE, clear counter=0.
  - The storage array is NOT reset; its contents are undefined until written or cleared.
- Access qualifier: acc_ok = en & (state==IDLE) & ~clr_req.
- Write: if acc_ok & ~wr_bar & addr<DEPTH, then mem[addr]<=din at the edge.
- Read: if acc_ok & ~rd_bar, then on the next edge:
  - dout <= mem[addr] and rd_valid=1 for exactly one cycle.
  - Read latency is 1 cycle; back-to-back reads each produce a pulse.
- Simultaneous read and write to the same address: write-first, so dout=din. To different addresses, both are performed.
- Out-of-range address (addr>=DEPTH): the write is dropped. A read returns dout=0 with rd_valid=1.
- No read in a cycle: rd_valid=0, and dout holds its last value (see Optional Feature).
- Clear state machine, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req=1 at an edge. Any access in that same cycle is dropped; clear has priority.
  - In CLEAR: busy=1; each edge writes mem[cnt]<=0 and increments cnt, starting from 0.
  - When cnt==DEPTH-1 is written: cnt<=0, state<=IDLE, busy<=0.
  - Net effect: clr_req sampled at edge N gives busy high for exactly DEPTH cycles (edges N+1..N+DEPTH). The first access is accepted in the cycle after busy falls.
- During CLEAR:
  - en, wr_bar, rd_bar and clr_req are ignored; rd_valid stays 0.
  - A read accepted just before clr_req completes normally; the registered stage is unaffected.
- Reset mid-clear aborts the sequence: busy=0, IDLE, and any words not yet reached keep their old contents.

Optional Feature:
- Macro: REG_FILE_TRISTATE_OUT_EN.
- Defined: dout is driven only while rd_valid=1 and is high-Z ('z) in every other cycle, including during reset and CLEAR. This allows several instances to share one read bus.
- Undefined: dout is always driven, holding its last read value (0 after reset).

Decomposition:
- Package reg_file_pkg holds:
  - state enum {IDLE, CLEAR}
  - helper function clog2_min1 (guarantees AW>=1)
  - localparam default values
- Sub-module reg_word: one WIDTH-bit row with we, d, clr inputs and q output; synchronous write, no reset. The top instantiates DEPTH rows with a generate loop.
- The address decode, read mux, forwarding, output register and clear FSM stay in reg_file_mem.

Test Plan:
- Reset, then write 0xA5 to addr 3 (en=1, wr_bar=0); read addr 3 next cycle -> rd_valid pulses one cycle after the read, dout=0xA5.
- Same-cycle write 0x3C and read at addr 7 -> next cycle dout=0x3C (write-first), rd_valid=1.
- Fill all 16 words with addr^0x55, pulse clr_req -> busy=1 for exactly 16 cycles. Accesses attempted during busy are ignored (rd_valid=0). Afterwards every address reads 0x00.
- en=0 with wr_bar=0, din=0xFF at addr 2 -> mem[2] unchanged; a read with en=0 gives no rd_valid.
- DEPTH=10: write 0x77 to addr 12 -> no array change; read addr 12 -> dout=0x00, rd_valid=1.
- Start clear, assert rst_n=0 after 5 busy cycles -> busy=0 next edge; words 0..4 read 0, words 5..15 keep prior data. With REG_FILE_TRISTATE_OUT_EN defined, dout=='z whenever rd_valid=0.
